// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
//   NUM_ROWS / NUM_COLS : keypad matrix size
//   state_e             : debounce FSM states
//   frame_res_e         : classification of one full scan frame
//   key_code_t          : 4-bit key code, row_idx*4 + col_idx
//   sat_hits()          : hit counter add, saturating at 2
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int ROW_W    = 2;
  localparam int COL_W    = 2;

  typedef logic [ROW_W+COL_W-1:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    PRESSED,
    RELEASE
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_res_e;

  // Only "zero / one / more than one" matters, so the sum is clamped at 2.
  function automatic logic [1:0] sat_hits(input logic [1:0] acc, input logic [2:0] add);
    logic [2:0] sum;
    sum = {1'b0, acc} + add;
    return (sum >= 3'd2) ? 2'd2 : sum[1:0];
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle.
//   row       : row drive, active-low, one row low at a time
//   col       : column sense, active-low, pulled up on the board
//   key_code  : code of the last accepted key
//   key_valid : one-cycle pulse per accepted (or repeated) key
//   key_down  : high while the accepted key is held
// Modport master is the scanner side; slave is the board/user side.
interface keypad_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row;
  logic [NUM_COLS-1:0] col;
  key_code_t           key_code;
  logic                key_valid;
  logic                key_down;

  modport master (output row, key_code, key_valid, key_down, input col);
  modport slave  (input row, key_code, key_valid, key_down, output col);
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM for the keypad scanner.
// Consumes one classified frame per frame_tick and turns stable presses
// into key events.
//   clk, rst   : clock, synchronous active-high reset
//   frame_tick : one-cycle strobe at the end of each scan frame
//   result     : frame classification (NONE / SINGLE / MULTI)
//   code       : key code of the first hit in the frame
//   key_code   : last accepted key code (held after release)
//   key_valid  : pulse the cycle after the accepting frame end
//   key_down   : high from accept until release is debounced
// Optional feature: define KEY_REPEAT_EN for auto-repeat pulses while held.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 125,
  parameter int REPEAT_RATE    = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  frame_res_e result,
  input  key_code_t  code,
  output key_code_t  key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  if (DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_debounce: DEBOUNCE_SCANS, REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  key_code_t        cand, cand_n;
  logic             accept, release_done, rep_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  // Transitions only happen on frame_tick; between ticks everything holds.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cand_n       = cand;
    accept       = 1'b0;
    release_done = 1'b0;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (result == SINGLE) begin
            cand_n = code;
            cnt_n  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_n = PRESSED;
              accept  = 1'b1;
            end else begin
              state_n = CAND;
            end
          end
        end
        CAND: begin
          if (result == SINGLE && code == cand) begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt_n >= CNT_W'(DEBOUNCE_SCANS)) begin
              state_n = PRESSED;
              accept  = 1'b1;
            end
          end else if (result == SINGLE) begin
            cand_n = code;
            cnt_n  = CNT_W'(1);
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PRESSED: begin
          if (result == NONE) begin
            cnt_n = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_n      = IDLE;
              release_done = 1'b1;
            end else begin
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (result == NONE) begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt_n >= CNT_W'(DEBOUNCE_SCANS)) begin
              state_n      = IDLE;
              release_done = 1'b1;
            end
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  // Down-counter of frames to the next repeat. Only frames that start and
  // end in PRESSED count; RELEASE frames leave it untouched.
  logic [REP_W-1:0] rep_cnt;
  logic             rep_step;

  assign rep_step = frame_tick && state == PRESSED && state_n == PRESSED;
  assign rep_fire = rep_step && rep_cnt == REP_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (accept) begin
      rep_cnt <= REP_W'(REPEAT_DELAY);
    end else if (rep_step) begin
      rep_cnt <= rep_fire ? REP_W'(REPEAT_RATE) : rep_cnt - REP_W'(1);
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= accept | rep_fire;
      if (accept) begin
        key_code <= cand_n;
        key_down <= 1'b1;
      end else if (release_done) begin
        key_down <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low per dwell period, samples
// the synchronized columns, classifies each full frame and hands the
// result to the debounce FSM.
//   clk, rst : clock, synchronous active-high reset
//   kp       : keypad_if.master (row, col, key_code, key_valid, key_down)
// Optional feature: define KEY_REPEAT_EN for auto-repeat (see keypad_debounce).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 125,
  parameter int REPEAT_RATE    = 25
) (
  input logic      clk,
  input logic      rst,
  keypad_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [NUM_ROWS-1:0] ROW_ONE = NUM_ROWS'(1);

  logic [DIV_W-1:0]    dwell_cnt;
  logic [ROW_W-1:0]    row_idx, row_idx_next;
  logic                scan_tick, frame_tick;
  logic [NUM_COLS-1:0] col_meta, col_sync, row_hits;
  logic [1:0]          acc_hits, hits_upd;
  key_code_t           acc_code, code_upd;
  logic [2:0]          row_n;
  logic [COL_W-1:0]    low_col;
  frame_res_e          frame_res;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the
  // two synchronizer stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= kp.col;
      col_sync <= col_meta;
    end
  end

  assign scan_tick    = (dwell_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_tick   = scan_tick && (row_idx == ROW_W'(NUM_ROWS - 1));
  assign row_idx_next = row_idx + ROW_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
      row_idx   <= '0;
      kp.row    <= ~ROW_ONE;
    end else if (scan_tick) begin
      dwell_cnt <= '0;
      row_idx   <= row_idx_next;
      kp.row    <= ~(ROW_ONE << row_idx_next);
    end else begin
      dwell_cnt <= dwell_cnt + DIV_W'(1);
    end
  end

  // NOTE: every signal written here gets a value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    row_hits = ~col_sync;
    row_n    = '0;
    low_col  = '0;
    // Walk from the top column down so the last hit seen is the lowest one.
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (row_hits[c]) begin
        row_n   = row_n + 3'd1;
        low_col = COL_W'(c);
      end
    end
    hits_upd = sat_hits(acc_hits, row_n);
    // Rows are scanned in ascending order, so the first row with a hit
    // already supplies the lowest-row code.
    code_upd = (acc_hits == 2'd0 && row_n != 3'd0) ? {row_idx, low_col} : acc_code;
    case (hits_upd)
      2'd0:    frame_res = NONE;
      2'd1:    frame_res = SINGLE;
      default: frame_res = MULTI;
    endcase
  end

  // Accumulators include the current row combinationally, so at frame end
  // the result covers all four rows and the registers clear for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hits <= '0;
      acc_code <= '0;
    end else if (frame_tick) begin
      acc_hits <= '0;
      acc_code <= '0;
    end else if (scan_tick) begin
      acc_hits <= hits_upd;
      acc_code <= code_upd;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_RATE   (REPEAT_RATE)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .result    (frame_res),
    .code      (code_upd),
    .key_code  (kp.key_code),
    .key_valid (kp.key_valid),
    .key_down  (kp.key_down)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (16 cycles per frame). A keypad model pulls col[c] low while row[r] is
// low and key (r,c) is held.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int FRAME = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] held = '0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;
  int pulse_q[$];

  keypad_if kp ();

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2),
    .REPEAT_DELAY  (3),
    .REPEAT_RATE   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    kp.col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp.row[r] && held[r*4+c]) kp.col[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      pulse_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n cycles; returns just after a falling edge, well clear of posedge.
  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    held = '0;
    rst  = 1'b1;
    run_cycles(2);
    rst = 1'b0;
    pulse_cnt = 0;
    last_pulse_cyc = -1;
    pulse_q.delete();
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] row;
  } row_vec_t;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulses;
    int          last_cyc;
    logic [3:0]  code;
    logic        down;
    string       name;
  } step_t;

  row_vec_t row_vecs[10];
  step_t    steps[17];

  initial begin
    int p0;
    int exp_rep[4];

    row_vecs = '{
      '{0, 4'b1110}, '{3, 4'b1110}, '{4, 4'b1101}, '{7, 4'b1101}, '{8, 4'b1011},
      '{12, 4'b0111}, '{15, 4'b0111}, '{16, 4'b1110}, '{20, 4'b1101}, '{28, 4'b0111}
    };

    // Cumulative expectations from reset; frame n ends at cycle 16*n.
    steps = '{
      '{16'h0200, 1, 0, -1,  4'd0, 1'b0, "hold21_f1"},
      '{16'h0200, 1, 1, 32,  4'd9, 1'b1, "hold21_accept"},
      '{16'h0200, 3, 1, 32,  4'd9, 1'b1, "hold21_held"},
      '{16'h0000, 1, 1, 32,  4'd9, 1'b1, "rel21_f1"},
      '{16'h0000, 1, 1, 32,  4'd9, 1'b0, "rel21_done"},
      '{16'h0008, 1, 1, 32,  4'd9, 1'b0, "bounce03_a"},
      '{16'h0000, 1, 1, 32,  4'd9, 1'b0, "bounce03_b"},
      '{16'h0008, 1, 1, 32,  4'd9, 1'b0, "bounce03_c"},
      '{16'h0000, 1, 1, 32,  4'd9, 1'b0, "bounce03_d"},
      '{16'h0008, 1, 1, 32,  4'd9, 1'b0, "bounce03_e"},
      '{16'h0000, 1, 1, 32,  4'd9, 1'b0, "bounce03_f"},
      '{16'h0008, 2, 2, 240, 4'd3, 1'b1, "stable03"},
      '{16'h0000, 2, 2, 240, 4'd3, 1'b0, "rel03"},
      '{16'h8010, 3, 2, 240, 4'd3, 1'b0, "multi_idle"},
      '{16'h0010, 2, 3, 352, 4'd4, 1'b1, "key10_alone"},
      '{16'h8010, 2, 3, 352, 4'd4, 1'b1, "key10_plus33"},
      '{16'h0000, 2, 3, 352, 4'd4, 1'b0, "rel_both"}
    };

    // Reset state and idle row walk.
    do_reset();
    foreach (row_vecs[i]) begin
      for (int n = 0; n < 64 && cyc < row_vecs[i].cyc; n++) run_cycles(1);
      check($sformatf("row_at_%0d", row_vecs[i].cyc), kp.row, row_vecs[i].row);
      check($sformatf("idle_code_%0d", row_vecs[i].cyc), kp.key_code, 0);
      check($sformatf("idle_down_%0d", row_vecs[i].cyc), kp.key_down, 0);
    end
    run_cycles(40);
    check("idle_no_pulse", pulse_cnt, 0);

`ifndef KEY_REPEAT_EN
    // Frame-aligned key sequences.
    do_reset();
    foreach (steps[i]) begin
      held = steps[i].keys;
      run_cycles(steps[i].frames * FRAME);
      check({steps[i].name, "_pulses"}, pulse_cnt, steps[i].pulses);
      check({steps[i].name, "_pulse_cyc"}, last_pulse_cyc, steps[i].last_cyc);
      check({steps[i].name, "_code"}, kp.key_code, steps[i].code);
      check({steps[i].name, "_down"}, kp.key_down, steps[i].down);
    end
`endif

    // Reset mid-row 2 with key (3,2) held, then re-accept after reset.
    do_reset();
    held = 16'h4000;
    run_cycles(2 * FRAME);
    check("k32_pre_code", kp.key_code, 14);
    check("k32_pre_down", kp.key_down, 1);
    run_cycles(10);
    check("k32_mid_row2", kp.row, 4'b1011);
    rst = 1'b1;
    run_cycles(1);
    check("rst_row", kp.row, 4'b1110);
    check("rst_code", kp.key_code, 0);
    check("rst_down", kp.key_down, 0);
    check("rst_valid", kp.key_valid, 0);
    rst = 1'b0;
    p0 = pulse_cnt;
    run_cycles(2 * FRAME);
    check("k32_re_pulses", pulse_cnt, p0 + 1);
    check("k32_re_pulse_cyc", last_pulse_cyc, 32);
    check("k32_re_code", kp.key_code, 14);
    check("k32_re_down", kp.key_down, 1);

`ifdef KEY_REPEAT_EN
    // Auto-repeat: accept at frame 2, then +3 frames, then every 2 frames.
    do_reset();
    held = 16'h0020;
    run_cycles(10 * FRAME);
    exp_rep = '{32, 80, 112, 144};
    check("rep_pulses", pulse_cnt, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rep_cyc_%0d", i), (pulse_q.size() > i) ? pulse_q[i] : -1, exp_rep[i]);
    check("rep_code", kp.key_code, 5);
    check("rep_down", kp.key_down, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad: drives one row low at a time, samples the column lines, and debounces the result.
- Emits a 4-bit key code with a one-cycle valid pulse per accepted press.
- Input-side counterpart of the multiplexed 8-digit seven-segment scan driver; shares its scan-timing style and active-low select convention.
- Sits between board keypad pins and user logic, for example a display or menu controller.

Parameters:
- SCAN_DIV, 100_000: clock cycles each row stays driven (row dwell).
- DEBOUNCE_SCANS, 4: consecutive identical full frames needed to accept a press or a release.
- REPEAT_DELAY, 125: frames from accept to first auto-repeat (KEY_REPEAT_EN only).
- REPEAT_RATE, 25: frames between later auto-repeats (KEY_REPEAT_EN only).

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- row  out  4  row drive, active-low, exactly one bit low at a time.
- col  in  4  column sense, active-low; externally pulled up.
- key_code  out  4  code of the last accepted key, equal to row_idx*4 + col_idx.
- key_valid  out  1  one-cycle pulse when a key is accepted (or repeated).
- key_down  out  1  high while the accepted key is held.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: row=4'b1110, key_code=0, key_valid=0, key_down=0, dwell counter=0, row_idx=0, FSM=IDLE, all frame and debounce counters 0.
- col passes through a 2-flop synchronizer before any use. Reset values of the synchronizer flops are 4'b1111.
- Dwell counter runs 0..SCAN_DIV-1. On its last count (scan tick), the synced col is sampled for the current row_idx.
- On the same tick, row_idx advances (wrapping 3->0) and row becomes ~(1<<row_idx_next).
- Frame: rows 0..3. The frame-end tick is the scan tick of row 3.
- Per-frame accumulators: hit count, saturating at 2, and first hit code (lowest row, then lowest col). These clear at the start of each frame.
- Frame result, evaluated at frame-end: NONE (0 hits), SINGLE(code) (exactly 1 hit), MULTI (2 or more hits).
- FSM states: IDLE, CAND, PRESSED, RELEASE.
  - IDLE: SINGLE(c) -> CAND with cand=c, cnt=1. NONE and MULTI stay in IDLE.
  - CAND: SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> PRESSED. SINGLE(other) -> cand=other, cnt=1. NONE or MULTI -> IDLE.
  - PRESSED: NONE -> RELEASE with cnt=1. SINGLE and MULTI (any code) stay in PRESSED; no new event.
  - RELEASE: NONE -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> IDLE. Anything else -> PRESSED.
- Entering PRESSED: key_code<=cand, key_down<=1, key_valid=1 for exactly the cycle after the frame-end tick.
- Entering IDLE from RELEASE: key_down<=0 on the same edge. key_code holds its value.
- DEBOUNCE_SCANS=1: accept on the first SINGLE frame; release on the first NONE frame.
- rst mid-frame: scan restarts at row 0 on the next cycle; any pending key_valid pulse is dropped.

Optional Feature:
- KEY_REPEAT_EN defined: in PRESSED, a frame counter counts frame-end ticks. After REPEAT_DELAY frames, and then every REPEAT_RATE frames, key_valid pulses for one cycle with an unchanged key_code.
  - The counter resets on entry to PRESSED.
  - Frames spent in RELEASE pause the counter; they do not reset it.
- KEY_REPEAT_EN undefined: exactly one key_valid pulse per press. The repeat counter and the REPEAT_* parameters are unused.

Decomposition:
- Package keypad_pkg: NUM_ROWS=4, NUM_COLS=4, the FSM state enum, the frame-result enum {NONE, SINGLE, MULTI}, and the key-code typedef (4 bits).
- Sub-module keypad_debounce: takes frame_tick, result and code; outputs key_code, key_valid and key_down, plus the repeat logic.
- Scan timing, the synchronizer and the accumulators stay in the top level.

Test Plan:
All tests use SCAN_DIV=4 and DEBOUNCE_SCANS=2, giving 16 cycles per frame. The bench keypad model pulls col[c] low whenever row[r] is low and key (r,c) is held.
- Reset, no keys -> row steps 1110,1101,1011,0111 every 4 cycles and repeats; key_valid never asserts; key_code=0.
- Hold key (2,1) for 5 frames -> one key_valid pulse, one cycle after the 2nd frame-end; key_code=9, key_down=1. Release -> key_down falls at the 2nd empty frame-end.
- Key (0,3) bouncing (present/absent on alternate frames) for 6 frames, then stable -> no pulse during bounce; single pulse with code 3 after 2 stable frames.
- Keys (1,0) and (3,3) held from IDLE -> MULTI frames, no pulse. Press (1,0) alone first, then add (3,3) -> code 4 accepted; adding (3,3) produces no extra pulse.
- Assert rst mid-row 2 while key (3,2) is pressed -> outputs reset next cycle and row=1110; after release of rst, code 14 is accepted 2 frames later.
- With KEY_REPEAT_EN, REPEAT_DELAY=3, REPEAT_RATE=2, hold key 5 for 10 frames -> pulses at accept, then at +3 and every 2 frames after (4 pulses total).
